jam_cost_server: RTL
====================

// Module: jam_cost_server
// PURPOSE
//   Responder side of the JAM cost interface: owns the 8x8 worker/job cost table, answers every
//   W/J address from the JAM engine with Cost one cycle later, and sequences the engine.
//   Loads the table through a valid/ready stream and holds JAM in reset until the table is complete.
//   Captures MinCost/MatchCount on Valid, with a watchdog timeout.
// PARAMETERS
//   TIMEOUT_CYC  100000  SERVE cycles allowed without Valid before aborting (>=2, fits 17 bits)
// PORTS
//   CLK         in   1   clock, all state on rising edge
//   RST_N       in   1   asynchronous active-low reset
//   START       in   1   1-cycle pulse; begins a load/solve run from IDLE or DONE
//   LD_VALID    in   1   load stream valid
//   LD_DATA     in   7   cost entry; stream order index = W*8+J (W-major, 64 entries)
//   LD_READY    out  1   load stream ready
//   W           in   3   worker address from JAM
//   J           in   3   job address from JAM
//   Cost        out  7   registered table[W*8+J]
//   JAM_RST     out  1   active-high reset to JAM engine
//   Valid       in   1   JAM result valid
//   MatchCount  in   4   JAM match count
//   MinCost     in   10  JAM minimum cost
//   DONE        out  1   run finished (sticky until next START)
//   TIMEOUT     out  1   run ended by watchdog (sticky until next START)
//   RES_MIN     out  10  captured MinCost
//   RES_CNT     out  4   captured MatchCount
// BEHAVIOUR
//   - Reset: state IDLE; LD_READY=0, Cost=0, JAM_RST=1, DONE=0, TIMEOUT=0, RES_MIN=0, RES_CNT=0;
//     load index=0, watchdog=0. Table contents are not reset.
//   - FSM: IDLE -START-> LOAD -64th beat-> RELEASE -> SERVE -Valid|watchdog-> DONE -START-> LOAD.
//   - LOAD: LD_READY=1; a beat transfers when LD_VALID&LD_READY; table[idx]<=LD_DATA, idx+1 (6 bit).
//     After the beat at idx=63: LD_READY=0 next cycle, go RELEASE, idx wraps to 0.
//   - LD_VALID is ignored outside LOAD. START is ignored in LOAD/RELEASE/SERVE.
//   - RELEASE: one cycle, JAM_RST still 1. JAM_RST=0 in SERVE only; it returns to 1 in the cycle
//     after the FSM enters DONE.
//   - SERVE: Cost <= table[{W,J}] every cycle (latency exactly 1; address changes each cycle);
//     Cost=0 in every other state. Watchdog increments each SERVE cycle.
//   - Valid=1 in SERVE: RES_MIN<=MinCost, RES_CNT<=MatchCount, DONE<=1, go DONE.
//   - Watchdog reaches TIMEOUT_CYC-1 with Valid=0: DONE<=1, TIMEOUT<=1, RES_* unchanged.
//     If Valid and watchdog expiry fall in the same cycle, Valid wins (TIMEOUT=0).
//   - START in IDLE/DONE: clears DONE, TIMEOUT and the watchdog; goes to LOAD. Table is always
//     fully reloaded; there is no partial reuse.
//   - RST_N assertion at any time, including mid-load, forces the reset values immediately and
//     abandons the partial load.
// CONFIGURATION
//   JAM_COST_CHECKSUM_EN defined: extra output CHKSUM[12:0] = unsigned sum of all accepted LD_DATA
//     beats (max 64*127=8128). Cleared to 0 on entry to LOAD and by reset; stable from RELEASE onward.
//   Not defined: port and adder are absent; behaviour is otherwise identical.
// TESTING
//   1 Reset, START, stream 64 beats LD_DATA=(W+J) with LD_VALID always 1
//     -> LD_READY=0 after beat 64; JAM_RST falls 2 cycles after the last beat.
//   2 Same load with LD_VALID toggling every other cycle -> exactly 64 beats accepted, no entry skipped.
//   3 SERVE, W=3,J=5 -> Cost=8 the next cycle; W=7,J=7 the next cycle -> Cost=14.
//   4 SERVE, Valid=1 with MinCost=42, MatchCount=2 -> RES_MIN=42, RES_CNT=2, DONE=1, TIMEOUT=0,
//     JAM_RST=1.
//   5 TIMEOUT_CYC=16, Valid never asserted -> DONE=1, TIMEOUT=1 after 16 SERVE cycles;
//     next START clears both.
//   6 RST_N low after 20 beats -> LD_READY=0, Cost=0, JAM_RST=1 at once; next START needs 64 beats.
//     With JAM_COST_CHECKSUM_EN, all 64 beats =127 -> CHKSUM=8128.

Source files
------------

// File: rtl/jam_cost_if.sv
// Cost-server bus: load stream, JAM address/cost lookup and JAM result/status.
// slave = cost server side, master = the side feeding/observing it.
interface jam_cost_if;
  logic       START;
  logic       LD_VALID;
  logic [6:0] LD_DATA;
  logic       LD_READY;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       JAM_RST;
  logic       Valid;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;
  logic       DONE;
  logic       TIMEOUT;
  logic [9:0] RES_MIN;
  logic [3:0] RES_CNT;

  modport slave (
    input  START, LD_VALID, LD_DATA, W, J, Valid, MatchCount, MinCost,
    output LD_READY, Cost, JAM_RST, DONE, TIMEOUT, RES_MIN, RES_CNT
  );

  modport master (
    output START, LD_VALID, LD_DATA, W, J, Valid, MatchCount, MinCost,
    input  LD_READY, Cost, JAM_RST, DONE, TIMEOUT, RES_MIN, RES_CNT
  );
endinterface

// File: rtl/jam_cost_server.sv
// JAM cost server: loads the 8x8 cost table, serves Cost one cycle after W/J, captures the result.
// Optional macro JAM_COST_CHECKSUM_EN adds CHKSUM, the sum of all accepted load beats.
module jam_cost_server #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        CLK,
  input  logic        RST_N,
  jam_cost_if.slave   bus
`ifdef JAM_COST_CHECKSUM_EN
  ,
  output logic [12:0] CHKSUM
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_SERVE,
    S_DONE
  } state_t;

  localparam logic [16:0] WD_LAST = 17'(TIMEOUT_CYC - 1);

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  ld_idx;
  logic [16:0] wdog;
  logic [6:0]  cost_q;
  logic        done_q;
  logic        timeout_q;
  logic [9:0]  res_min_q;
  logic [3:0]  res_cnt_q;
  logic [6:0]  tab [64];

  logic ld_ready;
  logic jam_rst;
  logic beat;
  logic start_ok;
  logic capture;
  logic expire;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_LOAD;
      S_LOAD:         if (beat && ld_idx == 6'd63) state_d = S_RELEASE;
      S_RELEASE:      state_d = S_SERVE;
      S_SERVE:        if (capture || expire) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Valid takes priority over watchdog expiry in the same cycle.
  always_comb begin
    ld_ready = (state_q == S_LOAD);
    jam_rst  = (state_q != S_SERVE);
    beat     = ld_ready & bus.LD_VALID;
    start_ok = bus.START & ((state_q == S_IDLE) | (state_q == S_DONE));
    capture  = (state_q == S_SERVE) & bus.Valid;
    expire   = (state_q == S_SERVE) & ~bus.Valid & (wdog == WD_LAST);
  end

  always_ff @(posedge CLK) begin
    if (beat) tab[ld_idx] <= bus.LD_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_idx    <= '0;
      wdog      <= '0;
      cost_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      res_min_q <= '0;
      res_cnt_q <= '0;
    end else begin
      cost_q <= (state_q == S_SERVE) ? tab[{bus.W, bus.J}] : 7'd0;
      if (start_ok) ld_idx <= '0;
      else if (beat) ld_idx <= ld_idx + 6'd1;
      if (start_ok) wdog <= '0;
      else if (state_q == S_SERVE) wdog <= wdog + 17'd1;
      if (start_ok) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else if (capture) begin
        done_q    <= 1'b1;
        res_min_q <= bus.MinCost;
        res_cnt_q <= bus.MatchCount;
      end else if (expire) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef JAM_COST_CHECKSUM_EN
  logic [12:0] chksum_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        chksum_q <= '0;
    else if (start_ok) chksum_q <= '0;
    else if (beat)     chksum_q <= chksum_q + 13'(bus.LD_DATA);
  end

  assign CHKSUM = chksum_q;
`endif

  assign bus.LD_READY = ld_ready;
  assign bus.JAM_RST  = jam_rst;
  assign bus.Cost     = cost_q;
  assign bus.DONE     = done_q;
  assign bus.TIMEOUT  = timeout_q;
  assign bus.RES_MIN  = res_min_q;
  assign bus.RES_CNT  = res_cnt_q;

endmodule
